// File: rtl/serv_timer_responder.sv
// serv_timer_responder: mtime/mtimecmp machine timer answering SERV dbus cycles.
// Optional feature macro: SERV_TIMER_64BIT_EN (64-bit mtime/mtimecmp; default 32-bit).
module serv_timer_responder #(
    parameter int unsigned PRESCALE       = 1,
    parameter              RESET_STRATEGY = "MINI"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

`ifdef SERV_TIMER_64BIT_EN
    localparam int TW   = 64;
    localparam bit IS64 = 1'b1;
`else
    localparam int TW   = 32;
    localparam bit IS64 = 1'b0;
`endif

    localparam bit          RST_ALL = (RESET_STRATEGY == "MINI");
    localparam logic [15:0] PS_MAX  = 16'(PRESCALE - 1);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t        r_state;
    logic [15:0]   r_pre;
    logic [TW-1:0] r_mtime;
    logic [TW-1:0] r_mtimecmp;
    logic [31:0]   r_rdt;
    logic          r_irq;

    logic          w_req;
    logic          w_tick;
    logic          w_wr;
    logic          w_wr_time;
    logic [1:0]    w_word;
    logic [63:0]   w_time64;
    logic [63:0]   w_cmp64;
    logic [63:0]   w_time_nxt;
    logic [63:0]   w_cmp_nxt;
    logic [31:0]   w_rd;

    // Replace only the byte lanes selected by sel.
    function automatic logic [31:0] f_merge(
        input logic [31:0] old,
        input logic [31:0] dat,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
        end
        return res;
    endfunction

    assign w_word   = i_wb_adr[3:2];
    assign w_req    = i_wb_cyc & (r_state == S_IDLE);
    assign w_tick   = (r_pre == PS_MAX);
    assign w_time64 = 64'(r_mtime);
    assign w_cmp64  = 64'(r_mtimecmp);

    // Upper words do not exist in the 32-bit build, so writes to them are dropped.
    assign w_wr = w_req & i_wb_we & (|i_wb_sel) & (IS64 | ~w_word[0]);

    // Next-state of mtime/mtimecmp; a bus write to mtime suppresses that tick.
    always_comb begin
        w_time_nxt = w_time64;
        w_cmp_nxt  = w_cmp64;
        w_wr_time  = 1'b0;
        if (w_wr) begin
            case (w_word)
                2'd0: begin
                    w_time_nxt[31:0] = f_merge(w_time64[31:0], i_wb_dat, i_wb_sel);
                    w_wr_time        = 1'b1;
                end
                2'd1: begin
                    w_time_nxt[63:32] = f_merge(w_time64[63:32], i_wb_dat, i_wb_sel);
                    w_wr_time         = 1'b1;
                end
                2'd2: w_cmp_nxt[31:0]  = f_merge(w_cmp64[31:0], i_wb_dat, i_wb_sel);
                default: w_cmp_nxt[63:32] = f_merge(w_cmp64[63:32], i_wb_dat, i_wb_sel);
            endcase
        end
        if (!w_wr_time && w_tick) begin
            w_time_nxt = w_time64 + 64'd1;
        end
    end

    // Read mux; upper words are zero in the 32-bit build via zero extension.
    always_comb begin
        w_rd = 32'd0;
        case (w_word)
            2'd0:    w_rd = w_time64[31:0];
            2'd1:    w_rd = w_time64[63:32];
            2'd2:    w_rd = w_cmp64[31:0];
            default: w_rd = w_cmp64[63:32];
        endcase
    end

    // Responder FSM, prescaler, timer registers and registered interrupt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pre   <= 16'd0;
            if (RST_ALL) begin
                r_mtime    <= '0;
                r_mtimecmp <= '1;
                r_rdt      <= 32'd0;
                r_irq      <= 1'b0;
            end
        end else begin
            r_pre      <= w_tick ? 16'd0 : r_pre + 16'd1;
            r_mtime    <= w_time_nxt[TW-1:0];
            r_mtimecmp <= w_cmp_nxt[TW-1:0];
            r_irq      <= (r_mtime >= r_mtimecmp);
            case (r_state)
                S_IDLE: begin
                    if (i_wb_cyc) begin
                        r_state <= S_ACK;
                        r_rdt   <= i_wb_we ? 32'd0 : w_rd;
                    end else begin
                        r_rdt   <= 32'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdt   <= 32'd0;
                end
            endcase
        end
    end

    assign o_wb_ack    = (r_state == S_ACK);
    assign o_wb_rdt    = r_rdt;
    assign o_timer_irq = r_irq;

endmodule

// File: tb/tb_serv_timer_responder.sv
// tb_serv_timer_responder: randomized scoreboard bench for serv_timer_responder.
// Reference model tracks mtime/mtimecmp as plain 64-bit integers per cycle.
module tb_serv_timer_responder;

    localparam int PS = 3;

`ifdef SERV_TIMER_64BIT_EN
    localparam bit          IS64 = 1'b1;
    localparam logic [63:0] MASK = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam bit          IS64 = 1'b0;
    localparam logic [63:0] MASK = 64'h0000_0000_FFFF_FFFF;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;
    logic        irq;

    serv_timer_responder #(
        .PRESCALE       (PS),
        .RESET_STRATEGY ("MINI")
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wb_adr    (adr),
        .i_wb_dat    (dat),
        .i_wb_sel    (sel),
        .i_wb_we     (we),
        .i_wb_cyc    (cyc),
        .o_wb_rdt    (rdt),
        .o_wb_ack    (ack),
        .o_timer_irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        rdv;
        logic [31:0] rdt;
        logic        irq;
        int          cyc_no;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    // Reference model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    int          m_pre;
    logic        m_ack;
    logic        m_rdv;
    logic [31:0] m_rdt;
    logic        m_irq;

    // Apply the effect of the clock edge that just consumed the current inputs.
    task automatic model_edge();
        logic [63:0] rd64;
        logic [31:0] rd;
        logic        req;
        logic        tick;
        logic        wrote_time;
        int          w;
        int          sh;
        if (rst) begin
            m_time = 64'd0;
            m_cmp  = MASK;
            m_pre  = 0;
            m_ack  = 1'b0;
            m_rdv  = 1'b0;
            m_rdt  = 32'd0;
            m_irq  = 1'b0;
            return;
        end
        w    = int'(adr[3:2]);
        sh   = (w % 2) * 32;
        rd64 = (w < 2) ? m_time : m_cmp;
        rd   = rd64[sh +: 32];
        req  = cyc && !m_ack;
        tick = (m_pre == PS - 1);
        m_pre = tick ? 0 : m_pre + 1;
        m_irq = (m_time >= m_cmp);
        wrote_time = 1'b0;
        if (req && we && sel != 4'd0 && (IS64 || sh == 0)) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                    if (w < 2) m_time[sh + 8*b +: 8] = dat[8*b +: 8];
                    else       m_cmp[sh + 8*b +: 8]  = dat[8*b +: 8];
                end
            end
            wrote_time = (w < 2);
        end
        if (!wrote_time && tick) m_time = (m_time + 64'd1) & MASK;
        m_ack = req;
        m_rdv = req && !we;
        m_rdt = (req && !we) ? rd : 32'd0;
    endtask

    // One cycle: model the edge just past, then queue what the DUT must show now.
    task automatic next();
        exp_t e;
        @(negedge clk);
        cyc_no++;
        model_edge();
        e.ack    = m_ack;
        e.rdv    = m_rdv;
        e.rdt    = m_rdt;
        e.irq    = m_irq;
        e.cyc_no = cyc_no;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        cyc = 1'b0;
        for (int i = 0; i < n; i++) next();
    endtask

    task automatic xfer(input logic w_en, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int guard;
        cyc = 1'b1;
        we  = w_en;
        adr = a;
        dat = d;
        sel = s;
        guard = 0;
        do begin
            next();
            guard++;
        end while (!m_ack && guard < 4);
        cyc = 1'b0;
    endtask

    task automatic chk(input string name, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
        end
    endtask

    // Monitor: pop one expectation per cycle and compare against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() == 0) continue;
            e = q.pop_front();
            chk("ack", e.cyc_no, 32'(ack), 32'(e.ack));
            chk("irq", e.cyc_no, 32'(irq), 32'(e.irq));
            if (e.rdv) chk("rdt", e.cyc_no, rdt, e.rdt);
            else if (!e.ack) chk("rdt_idle", e.cyc_no, rdt, 32'd0);
        end
    end

    initial begin
        int          r;
        int          w;
        logic [31:0] base;
        rst = 1'b1;
        cyc = 1'b0;
        we  = 1'b0;
        adr = 32'd0;
        dat = 32'd0;
        sel = 4'd0;
        idle(3);
        rst = 1'b0;
        idle(10);
        xfer(1'b0, 32'h0, 32'd0, 4'h0);

        xfer(1'b1, 32'h8, 32'h20, 4'hF);
        xfer(1'b1, 32'hC, 32'h0, 4'hF);
        idle(90);
        xfer(1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF);
        xfer(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
        idle(3);

        xfer(1'b1, 32'h0, 32'h0000_00AB, 4'b0001);
        idle(5);
        xfer(1'b0, 32'h0, 32'd0, 4'h0);

        xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
        idle(4);
        xfer(1'b0, 32'h0, 32'd0, 4'h0);
        xfer(1'b0, 32'h4, 32'd0, 4'h0);

        xfer(1'b1, 32'h8, 32'h1234, 4'hF);
        rst = 1'b1;
        next();
        rst = 1'b0;
        xfer(1'b0, 32'h8, 32'd0, 4'h0);

        // back-to-back requests with cyc held high
        cyc = 1'b1;
        we  = 1'b0;
        adr = 32'h0;
        for (int i = 0; i < 6; i++) next();
        cyc = 1'b0;

        for (int c = 0; c < 2500; c++) begin
            next();
            if (rst) begin
                rst = 1'b0;
                continue;
            end
            if (cyc && !m_ack) continue;
            if (m_ack && we && adr[3:2] == 2'd2 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                cyc = 1'b0;
                continue;
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                cyc = 1'b0;
                continue;
            end
            r = $urandom_range(0, 7);
            if (r < 3) begin
                cyc = 1'b0;
                continue;
            end
            w    = $urandom_range(0, 3);
            base = m_time[31:0];
            cyc  = 1'b1;
            we   = ($urandom_range(0, 1) == 1);
            adr  = {$urandom_range(0, 32'h0FFF_FFFF), 4'b0000} | 32'(w * 4)
                   | 32'($urandom_range(0, 3));
            sel  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            case (w)
                0: dat = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                     : base + 32'($urandom_range(0, 3));
                2: dat = base + 32'($urandom_range(0, 60));
                default: dat = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            endcase
        end
        cyc = 1'b0;
        idle(4);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
